pc_unit: RTL
============

PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of all address ports and registers.
REQ-002 SHALL have parameter RESET_VECTOR, default 0: PC value loaded by reset.
REQ-003 SHALL have parameter TRAP_VECTOR, default 'h10: redirect target for traps.
REQ-004 SHALL have parameter RAS_DEPTH, default 4, range 2..16: return-address-stack entries.
REQ-005 SHALL have one clock and asynchronous active-high reset: clk in 1 (rising-edge clock); reset in 1 (asynchronous, active-high).
REQ-006 SHALL have these ports:
- update_pc in 1: advance strobe, sampled on clk.
- addr_offset in DATA_WIDTH: branch/JAL immediate.
- alu_result in DATA_WIDTH: JALR target; bit 0 is the branch condition.
- jump_type in 3: `JUMP_* codes from defines.v.
- rd_link in 1: rd is x1/x5.
- rs1_link in 1: rs1 is x1/x5.
- trap_req in 1: ecall/ebreak/illegal.
- mret in 1: return from trap.
- halt_req in 1: enter HALT.
- resume in 1: leave HALT.
- pc_current out DATA_WIDTH.
- pc_plus_4 out DATA_WIDTH.
- pc_next out DATA_WIDTH.
- epc out DATA_WIDTH: saved trap PC.
- misaligned out 1: computed target not word-aligned.
- ras_top out DATA_WIDTH: predicted return address.
- ras_empty out 1.
- halted out 1.

Function
REQ-007 SHALL compute pc_plus_4 = pc_current+4 and offset target = pc_current+addr_offset, both modulo 2^DATA_WIDTH, wrapping without any flag.
REQ-008 SHALL form the JALR target as alu_result with bit 0 forced to 0.
REQ-009 SHALL define the jump target as taken when the jump_type condition holds:
- JUMP_IF_0 with alu_result[0]=0, or JUMP_IF_1 with alu_result[0]=1 -> offset target.
- JUMP_JAL -> offset target.
- JUMP_JALR -> JALR target.
- JUMP_ZERO -> 0.
REQ-010 SHALL assert misaligned combinationally when the jump is taken and target[1:0]!=0; misaligned is 0 otherwise.
REQ-011 SHALL select pc_next combinationally with priority:
1. trap_req or misaligned -> TRAP_VECTOR.
2. mret -> epc.
3. taken jump -> jump target.
4. otherwise -> pc_plus_4.
REQ-012 SHALL implement a 3-state FSM: BOOT, RUN, HALT.
REQ-013 SHALL leave BOOT for RUN on the first clk edge after reset deasserts, holding PC at RESET_VECTOR on that edge.
REQ-014 SHALL, in RUN, load pc_next into the PC on a clk edge with update_pc=1, and hold the PC when update_pc=0.
REQ-015 SHALL enter HALT from RUN on a clk edge with halt_req=1, ignoring update_pc on that edge; halt_req takes priority over update_pc.
REQ-016 SHALL hold PC, epc and RAS in HALT, and return to RUN on an edge with resume=1; the PC does not advance on that edge.
REQ-017 SHALL assert halted only in HALT.
REQ-018 SHALL, on an advancing edge with trap_req or misaligned, load epc with pc_current; epc is otherwise held, and mret does not modify it.
REQ-019 SHALL treat simultaneous trap_req and mret as a trap; the mret is ignored.
REQ-020 SHALL, on an advancing, non-trapping edge, update the RAS as follows:
- Push pc_plus_4 on JAL/JALR with rd_link=1.
- Pop on JALR with rd_link=0 and rs1_link=1.
- On JALR with rd_link=1 and rs1_link=1, pop then push, so depth is unchanged and the top is replaced.
REQ-021 SHALL drive ras_top with the newest entry, and with 0 when empty.
REQ-022 SHALL, on push when full, overwrite the oldest entry (circular pointer) and keep the count at RAS_DEPTH.
REQ-023 SHALL ignore a pop when empty, leaving the pointer and count unchanged.
REQ-024 SHALL assert ras_empty when the count is 0.
REQ-025 SHALL keep the RAS advisory: ras_top never affects pc_next.

Reset
REQ-026 SHALL, while reset=1, asynchronously set:
- PC to RESET_VECTOR.
- epc to 0.
- RAS count, pointer and all entries to 0.
- FSM to BOOT.
REQ-027 SHALL therefore present, during reset: pc_current=RESET_VECTOR, halted=0, ras_empty=1, ras_top=0.
REQ-028 SHALL take effect immediately when reset asserts mid-operation (including in HALT), discarding any in-flight update.

Verification
REQ-029 SHALL be covered by a reset/boot test: reset, release, 3 update_pc pulses -> pc_current 0, 0 (BOOT edge), 4, 8.
REQ-030 SHALL be covered by a branch test: pc=0x40, JUMP_IF_1, alu_result=1, addr_offset=0xFFFFFFF8 -> pc=0x38; repeat with alu_result=0 -> pc=0x3C.
REQ-031 SHALL be covered by a trap test: pc=0x100, trap_req with mret=1 -> pc=0x10 and epc=0x100; then mret -> pc=0x100.
REQ-032 SHALL be covered by a misaligned test: JUMP_JAL from 0x20, addr_offset=6 -> misaligned=1 and pc=0x10 and epc=0x20; addr_offset=8 -> misaligned=0 and pc=0x28.
REQ-033 SHALL be covered by a RAS test: 5 linking JALs at pcs 0,0x100,0x200,0x300,0x400 with depth 4 -> ras_top=0x404; 4 pops -> 0x304, 0x204, 0x104, then ras_empty=1 and ras_top=0; a further pop leaves it empty.
REQ-034 SHALL be covered by a halt/reset test: halt_req with update_pc at pc=0x8 -> halted=1 and pc=0x8; resume -> no advance; reset asserted while halted -> pc=RESET_VECTOR immediately, halted=0.

Source files
------------

// File: rtl/pc_unit.sv
// pc_unit: program counter with branch/jump targeting, trap/mret redirection, halt control and an advisory return-address stack.
module pc_unit #(
  parameter int DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [DATA_WIDTH-1:0] TRAP_VECTOR = 'h10,
  parameter int RAS_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  update_pc,
  input  logic [DATA_WIDTH-1:0] addr_offset,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic [2:0]            jump_type,
  input  logic                  rd_link,
  input  logic                  rs1_link,
  input  logic                  trap_req,
  input  logic                  mret,
  input  logic                  halt_req,
  input  logic                  resume,
  output logic [DATA_WIDTH-1:0] pc_current,
  output logic [DATA_WIDTH-1:0] pc_plus_4,
  output logic [DATA_WIDTH-1:0] pc_next,
  output logic [DATA_WIDTH-1:0] epc,
  output logic                  misaligned,
  output logic [DATA_WIDTH-1:0] ras_top,
  output logic                  ras_empty,
  output logic                  halted
);
  localparam logic [2:0] JUMP_IF_0 = 3'd1;
  localparam logic [2:0] JUMP_IF_1 = 3'd2;
  localparam logic [2:0] JUMP_JAL  = 3'd3;
  localparam logic [2:0] JUMP_JALR = 3'd4;
  localparam logic [2:0] JUMP_ZERO = 3'd5;
  localparam logic [1:0] BOOT = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HALT = 2'd2;
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);

  logic [1:0]            state;
  logic [DATA_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] epc_q;
  logic [DATA_WIDTH-1:0] ras [RAS_DEPTH];
  logic [PW-1:0]         ras_ptr;
  logic [CW-1:0]         ras_cnt;
  logic [DATA_WIDTH-1:0] offset_tgt;
  logic [DATA_WIDTH-1:0] target;
  logic                  is_jal;
  logic                  is_jalr;
  logic                  taken;
  logic                  trap;
  logic                  advance;
  logic                  do_push;
  logic                  do_pop;
  logic [PW-1:0]         ptr_inc;
  logic [PW-1:0]         ptr_dec;

  always_comb begin
    is_jal     = jump_type == JUMP_JAL;
    is_jalr    = jump_type == JUMP_JALR;
    offset_tgt = pc_q + addr_offset;
    taken      = jump_type == JUMP_IF_0 ? !alu_result[0] :
                 jump_type == JUMP_IF_1 ? alu_result[0] :
                 is_jal || is_jalr || jump_type == JUMP_ZERO;
    target     = is_jalr ? {alu_result[DATA_WIDTH-1:1], 1'b0} :
                 jump_type == JUMP_ZERO ? '0 : offset_tgt;
    misaligned = taken && (target[1:0] != 2'b00);
    trap       = trap_req || misaligned;
    pc_next    = trap ? TRAP_VECTOR : mret ? epc_q : taken ? target : pc_plus_4;
    advance    = state == RUN && update_pc && !halt_req;
    do_push    = advance && !trap && rd_link && (is_jal || is_jalr);
    do_pop     = advance && !trap && is_jalr && rs1_link;
    ptr_inc    = ras_ptr == PW'(RAS_DEPTH - 1) ? '0 : ras_ptr + 1'b1;
    ptr_dec    = ras_ptr == '0 ? PW'(RAS_DEPTH - 1) : ras_ptr - 1'b1;
  end

  assign pc_current = pc_q;
  assign pc_plus_4  = pc_q + DATA_WIDTH'(4);
  assign epc        = epc_q;
  assign ras_empty  = ras_cnt == '0;
  assign ras_top    = ras_empty ? '0 : ras[ras_ptr];
  assign halted     = state == HALT;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= BOOT;
      pc_q  <= RESET_VECTOR;
      epc_q <= '0;
    end else begin
      case (state)
        BOOT:    state <= RUN;
        RUN:     if (halt_req) state <= HALT;
        HALT:    if (resume) state <= RUN;
        default: state <= BOOT;
      endcase
      if (advance) pc_q <= pc_next;
      if (advance && trap) epc_q <= pc_q;
    end
  end

  // a linking JALR that also pops on a non-empty stack just rewrites the top
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ras_ptr <= '0;
      ras_cnt <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) ras[i] <= '0;
    end else if (do_push && do_pop && !ras_empty) begin
      ras[ras_ptr] <= pc_plus_4;
    end else if (do_push) begin
      ras_ptr      <= ptr_inc;
      ras[ptr_inc] <= pc_plus_4;
      if (ras_cnt != CW'(RAS_DEPTH)) ras_cnt <= ras_cnt + 1'b1;
    end else if (do_pop && !ras_empty) begin
      ras_ptr <= ptr_dec;
      ras_cnt <= ras_cnt - 1'b1;
    end
  end
endmodule
